// File: rtl/image_ram_viewer_pkg.sv
// rtl/image_ram_viewer_pkg.sv - shared constants and types for the image RAM viewer
package image_ram_viewer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    localparam logic [1:0] DIG_DATA_LO = 2'd0;
    localparam logic [1:0] DIG_DATA_HI = 2'd1;
    localparam logic [1:0] DIG_BLANK   = 2'd2;
    localparam logic [1:0] DIG_ADDR    = 2'd3;

    // Active-low gfedcba with dp (bit 7) off; entry n encodes hex digit n.
    localparam logic [15:0][7:0] HEX_SSEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_sseg(input logic [3:0] nibble, input logic dp_on);
        return {~dp_on, HEX_SSEG[nibble][6:0]};
    endfunction

endpackage

// File: rtl/image_ram_viewer_if.sv
// rtl/image_ram_viewer_if.sv - host write/read/clear bus of the image RAM viewer
interface image_ram_viewer_if #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 3
);
    logic                     wr_en;
    logic [RAM_ADDR_BITS-1:0] wr_addr;
    logic [RAM_WIDTH-1:0]     wr_data;
    logic                     rd_en;
    logic [RAM_ADDR_BITS-1:0] rd_addr;
    logic [RAM_WIDTH-1:0]     rd_data;
    logic                     rd_valid;
    logic                     clr;
    logic                     busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/image_ram_viewer_sseg_scan4.sv
// rtl/image_ram_viewer_sseg_scan4.sv - 4-digit multiplexed seven-segment driver
module sseg_scan4
    import image_ram_viewer_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0][3:0] digits,
    input  logic [3:0]      blank,
    input  logic [3:0]      dp,
    output logic [3:0]      an,
    output logic [7:0]      sseg
);

    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [7:0]              sseg_q, sseg_d;
    logic [1:0]              idx;

    assign idx = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        refresh_d = refresh_q + REFRESH_BITS'(1);
        an_d      = ~(4'b0001 << idx);
        sseg_d    = blank[idx] ? SSEG_BLANK : hex_sseg(digits[idx], dp[idx]);
    end

    // Anode and segment registers update together so no digit ghosts onto its neighbour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_q <= '0;
            an_q      <= 4'b1110;
            sseg_q    <= SSEG_BLANK;
        end else begin
            refresh_q <= refresh_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: rtl/image_ram_viewer.sv
// rtl/image_ram_viewer.sv - image buffer with clear engine and address/data hex viewer
module image_ram_viewer
    import image_ram_viewer_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 3,
    parameter int SCAN_DIV      = 26,
    parameter int REFRESH_BITS  = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    image_ram_viewer_if.slave        bus,
    input  logic                     mode,
    input  logic [RAM_ADDR_BITS-1:0] sel_addr,
    input  logic                     freeze,
    output logic [RAM_ADDR_BITS-1:0] cur_addr,
    output logic [3:0]               an,
    output logic [7:0]               sseg
);

    localparam int DEPTH = 1 << RAM_ADDR_BITS;
    localparam int DW    = (RAM_WIDTH < 8) ? RAM_WIDTH : 8;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = RAM_ADDR_BITS'(DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    clr_state_e               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [RAM_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [SCAN_DIV-1:0]      dwell_q, dwell_d;
    logic [RAM_ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [RAM_WIDTH-1:0]     disp_word_q, disp_word_d;

    logic                     mem_we;
    logic [RAM_ADDR_BITS-1:0] mem_waddr;
    logic [RAM_WIDTH-1:0]     mem_wdata;
    logic [7:0]               disp8;

    // The sweep owns the write port; host writes are dropped while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (bus.wr_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rd_data_d   = bus.rd_en ? mem[bus.rd_addr] : rd_data_q;
        rd_valid_d  = bus.rd_en;
        dwell_d     = dwell_q;
        cur_addr_d  = cur_addr_q;
        disp_word_d = mem[cur_addr_q];

        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + RAM_ADDR_BITS'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Holding dwell at zero in manual mode makes a switch to autoscan start a fresh dwell.
        if (!mode) begin
            cur_addr_d = sel_addr;
            dwell_d    = '0;
        end else if (!freeze) begin
            dwell_d = dwell_q + SCAN_DIV'(1);
            if (dwell_q == '1) begin
                cur_addr_d = cur_addr_q + RAM_ADDR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            dwell_q     <= '0;
            cur_addr_q  <= '0;
            disp_word_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            dwell_q     <= dwell_d;
            cur_addr_q  <= cur_addr_d;
            disp_word_q <= disp_word_d;
        end
    end

    assign disp8        = 8'(disp_word_q[DW-1:0]);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == CLEAR);
    assign cur_addr     = cur_addr_q;

    sseg_scan4 #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_scan (
        .clk    (clk),
        .reset_n(reset_n),
        .digits ({4'(cur_addr_q), 4'h0, disp8[7:4], disp8[3:0]}),
        .blank  (4'b0100),
        .dp     ({bus.busy, 3'b000}),
        .an     (an),
        .sseg   (sseg)
    );

endmodule

// File: tb/tb_image_ram_viewer.sv
// tb/tb_image_ram_viewer.sv - scoreboard bench for image_ram_viewer
module tb_image_ram_viewer;

    localparam int W  = 8;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          mode;
    logic [AB-1:0] sel_addr;
    logic          freeze;
    logic [AB-1:0] cur_addr;
    logic [3:0]    an;
    logic [7:0]    sseg;

    image_ram_viewer_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    image_ram_viewer #(
        .RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .SCAN_DIV(3), .REFRESH_BITS(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .mode    (mode),
        .sel_addr(sel_addr),
        .freeze  (freeze),
        .cur_addr(cur_addr),
        .an      (an),
        .sseg    (sseg)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-response monitor: every rd_valid pulse consumes one expected word.
    always @(negedge clk) begin
        if (reset_n && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_data %0h expected no pulse", bus.rd_data);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [AB-1:0] a, input logic [7:0] e);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        exp_q.push_back(e);
        step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        logic [3:0] seen;
        logic       prev_busy;
        int         n, busy_cnt, dp_seen;

        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_en = 0; bus.rd_addr = 0; bus.clr = 0;
        mode = 0; sel_addr = 0; freeze = 0;

        #12 reset_n = 1'b0;
        #1;
        check("reset_an", 32'(an), 32'h0E);
        check("reset_sseg", 32'(sseg), 32'hFF);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_rd_data", 32'(bus.rd_data), 0);
        check("reset_cur_addr", 32'(cur_addr), 0);
        step(); step();
        reset_n = 1'b1;

        wr(5, 8'hA5);
        rd(5, 8'hA5);
        step();
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 8'h3C;
        bus.rd_en = 1; bus.rd_addr = 5;
        exp_q.push_back(8'hA5);
        step();
        bus.wr_en = 0; bus.rd_en = 0;
        rd(5, 8'h3C);
        wr(5, 8'hA5);
        step();

        mode = 0; sel_addr = 5;
        repeat (4) step();
        check("manual_cur_addr", 32'(cur_addr), 5);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            case (an)
                4'b1110: begin e = 8'h92; seen[0] = 1; end
                4'b1101: begin e = 8'h88; seen[1] = 1; end
                4'b1011: begin e = 8'hFF; seen[2] = 1; end
                4'b0111: begin e = 8'h92; seen[3] = 1; end
                default: e = 8'h00;
            endcase
            if (e == 8'h00) check("manual_an", 32'(an), 32'h0E);
            else            check("manual_sseg", 32'(sseg), 32'(e));
        end
        check("manual_digits_seen", 32'(seen), 32'hF);

        sel_addr = 0;
        step(); step();
        mode = 1;
        for (int k = 1; k <= 68; k++) begin
            step();
            if (k % 8 == 4) check("autoscan_cur_addr", 32'(cur_addr), 32'((k / 8) % 8));
        end
        freeze = 1;
        repeat (20) begin
            step();
            check("freeze_cur_addr", 32'(cur_addr), 0);
        end
        freeze = 0;
        repeat (3) step();
        check("unfreeze_hold", 32'(cur_addr), 0);
        step();
        check("unfreeze_step", 32'(cur_addr), 1);

        mode = 0; sel_addr = 3;
        for (int a = 0; a < 8; a++) wr(AB'(a), 8'hFF);
        n = 0;
        while (an == 4'b1011 && n < 40) begin step(); n++; end
        while (an != 4'b1011 && n < 40) begin step(); n++; end
        check("align_digit_timeout", 32'(n < 40), 1);
        bus.clr = 1;
        step();
        bus.clr = 0;
        busy_cnt = 0; dp_seen = 0; prev_busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && prev_busy && an == 4'b0111) begin
                dp_seen++;
                check("busy_addr_digit", 32'(sseg), 32'h30);
            end
            prev_busy = bus.busy;
            bus.wr_en = (i == 4); bus.wr_addr = 0; bus.wr_data = 8'h5A;
            step();
        end
        bus.wr_en = 0;
        check("busy_cycles", 32'(busy_cnt), 8);
        check("busy_dp_seen", 32'(dp_seen > 0), 1);
        check("busy_after_sweep", 32'(bus.busy), 0);
        for (int a = 0; a < 8; a++) rd(AB'(a), 8'h00);
        step();

        for (int a = 0; a < 8; a++) wr(AB'(a), 8'hFF);
        bus.clr = 1;
        @(posedge clk);
        @(negedge clk);
        bus.clr = 0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midclr_busy", 32'(bus.busy), 0);
        check("midclr_an", 32'(an), 32'h0E);
        check("midclr_sseg", 32'(sseg), 32'hFF);
        check("midclr_rd_valid", 32'(bus.rd_valid), 0);
        step(); step();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd(AB'(a), (a < 3) ? 8'h00 : 8'hFF);

        repeat (4) step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_ram_viewer.md
Name: image_ram_viewer

Overview:
Parametrised image buffer with a synchronous write port, a registered read port and a built-in 4-digit seven-segment viewer. The viewer shows one word as address plus data hex, either a host-selected address (manual) or all addresses stepped at a fixed dwell (autoscan). A clear engine zeroes the whole buffer on request. It sits between the image loader and the board display, and replaces the fixed single-word RAM/display top.

Parameters:
RAM_WIDTH, 8, data word width; display shows bits [7:0], zero-extended when RAM_WIDTH<8.
RAM_ADDR_BITS, 3, address width (1..4); depth = 2**RAM_ADDR_BITS.
SCAN_DIV, 26, autoscan dwell = 2**SCAN_DIV cycles per address.
REFRESH_BITS, 18, digit-multiplex counter width; digit period = 2**(REFRESH_BITS-2) cycles.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe; ignored while busy
wr_addr  in  RAM_ADDR_BITS  write address
wr_data  in  RAM_WIDTH  write data
rd_en  in  1  read strobe
rd_addr  in  RAM_ADDR_BITS  read address
rd_data  out  RAM_WIDTH  registered read data
rd_valid  out  1  one-cycle pulse with rd_data
clr  in  1  start clear sweep (level sampled; ignored while busy)
busy  out  1  clear sweep in progress
mode  in  1  0 = manual (show sel_addr), 1 = autoscan
sel_addr  in  RAM_ADDR_BITS  manual display address
freeze  in  1  autoscan hold: dwell counter and cur_addr stop
cur_addr  out  RAM_ADDR_BITS  address currently displayed
an  out  4  digit anodes, active-low
sseg  out  8  segments, active-low, sseg[7] = dp

Behaviour:
- Reset values: rd_data=0, rd_valid=0, busy=0, cur_addr=0, an=4'b1110, sseg=8'hFF, dwell and refresh counters=0, FSM=IDLE. RAM contents are not reset.
- Write: wr_en && !busy -> mem[wr_addr] <= wr_data at the edge.
- Read: rd_en at edge N -> rd_data = mem[rd_addr], rd_valid=1 after edge N (1-cycle latency). rd_data holds otherwise. Read is allowed while busy and returns the mid-sweep contents.
- Same-address write and read in one cycle: read-first, so rd_data returns the old word.
- Clear FSM: IDLE --clr--> CLEAR, with clear pointer = 0 and busy=1. CLEAR writes 0 to mem[ptr] each cycle and increments ptr. After writing the last address -> IDLE, busy=0. The sweep takes exactly 2**RAM_ADDR_BITS cycles. clr during CLEAR is ignored. Async reset mid-sweep -> IDLE, and the partially cleared contents remain.
- Display address: mode=0 -> cur_addr <= sel_addr, registered with 1-cycle lag. mode=1 -> dwell counter increments each cycle unless freeze. On wrap to 0, cur_addr increments modulo depth (last -> 0). Switching mode 0->1 keeps the current cur_addr and restarts the dwell count at 0.
- Display data: disp_word registered from mem[cur_addr] every cycle. Writes therefore appear on the display 1 cycle after the write, or 2 cycles if cur_addr changes at the same time.
- Digits: idx = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2].
  - idx 0: an=1110, data[3:0].
  - idx 1: an=1101, data[7:4].
  - idx 2: an=1011, blank 8'hFF.
  - idx 3: an=0111, cur_addr zero-extended to 4 bits, with dp lit on this digit (sseg[7]=0) while busy.
  - dp is off (1) on all other digits.
  - an and sseg are registered and change together.
- Hex encoding, active-low gfedcba: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.

Decomposition:
- Shared package holds: the hex-to-segment constant table, SSEG_BLANK=8'hFF, the FSM state encoding (IDLE=0, CLEAR=1) and the digit index constants.
- One natural sub-module, sseg_scan4: refresh counter plus 4:1 digit mux plus encoder. It takes four nibbles, a per-digit blank mask and a dp mask, and drives an and sseg.
- RAM, clear FSM and address/dwell logic stay in the top.

Test Plan:
- Run with SCAN_DIV=3, REFRESH_BITS=4.
- Reset: assert reset_n=0 mid-cycle -> outputs go immediately to an=1110, sseg=FF, busy=0, rd_valid=0.
- Write/read: write A5 to addr 5, then rd_en addr 5 next cycle -> rd_valid pulse with rd_data=A5 one cycle later. Same-cycle write 3C and read of addr 5 -> returns A5, and the next read returns 3C.
- Manual display: mode=0, sel_addr=5 holding A5 -> over 4 digit periods the bench sees an/sseg pairs 1110/92, 1101/88, 1011/FF, 0111/92.
- Autoscan: mode=1 -> cur_addr steps 0..7 every 8 cycles, wraps 7->0. freeze held 20 cycles -> cur_addr unchanged.
- Clear: fill all 8 addresses with FF, then pulse clr -> busy high for exactly 8 cycles, wr_en during the sweep is ignored, and all reads return 00 afterward. Address-digit dp=0 while busy.
- Reset mid-clear: assert reset_n=0 after 3 sweep cycles -> busy=0 at once, addrs 0-2 read 00, addrs 3-7 read FF.
